// File: rtl/spy_pkg.sv
// Shared opcode nibbles and byte-FSM encoding for the spy UART register master
// and its sibling blocks.
package spy_pkg;

  localparam logic [3:0] SET_D3 = 4'h3;
  localparam logic [3:0] SET_D2 = 4'h4;
  localparam logic [3:0] SET_D1 = 4'h5;
  localparam logic [3:0] SET_D0 = 4'h6;
  localparam logic [3:0] RD_LO  = 4'h8;
  localparam logic [3:0] RD_HI  = 4'h9;
  localparam logic [3:0] WR_LO  = 4'hA;
  localparam logic [3:0] WR_HI  = 4'hB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_D3,
    ST_TX_D2,
    ST_TX_D1,
    ST_TX_D0,
    ST_TX_OP,
    ST_RX_WAIT,
    ST_DONE
  } spy_state_e;

  // The opcode's high nibble carries direction and eadr bit 4.
  function automatic logic [7:0] op_byte(input logic write, input logic [4:0] addr);
    logic [3:0] hi;
    if (write) hi = addr[4] ? WR_HI : WR_LO;
    else       hi = addr[4] ? RD_HI : RD_LO;
    return {hi, addr[3:0]};
  endfunction

endpackage

// File: rtl/spy_rx_collect.sv
// Read-response collector: checks the 3/4/5/6 tag sequence, assembles the
// 16-bit result MSB-first and watches the inter-byte idle gap.
module spy_rx_collect
  import spy_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        spy_clk,
  input  logic        reset,
  input  logic        start,
  input  logic        active,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        byte_done,
  output logic        tag_err,
  output logic        timeout,
  output logic [15:0] result
);

  logic [23:0] count;
  logic [1:0]  nib_cnt;
  logic [11:0] shift;
  logic        tag_ok;

  // A byte arriving on the expiry cycle wins: timeout needs an idle cycle.
  always_comb begin
    tag_ok    = (rx_byte[7:4] == (SET_D3 + {2'b00, nib_cnt}));
    byte_done = active && rx_valid && tag_ok && (nib_cnt == 2'd3);
    tag_err   = active && rx_valid && !tag_ok;
    timeout   = active && !rx_valid && (count == TIMEOUT_CYCLES - 24'd1);
    result    = {shift, rx_byte[3:0]};
  end

  always_ff @(posedge spy_clk) begin
    if (reset || start) begin
      count   <= 24'd0;
      nib_cnt <= 2'd0;
      shift   <= 12'h000;
    end else if (active) begin
      if (rx_valid) begin
        count <= 24'd0;
        if (tag_ok) begin
          shift   <= {shift[7:0], rx_byte[3:0]};
          nib_cnt <= nib_cnt + 2'd1;
        end
      end else begin
        count <= count + 24'd1;
      end
    end
  end

endmodule

// File: rtl/spy_master.sv
// Host-command to UART byte-protocol master: writes send four data-nibble bytes
// plus an opcode, reads send an opcode and collect a four-byte response.
// Handshakes: a transfer happens on a clock edge where valid && ready; a TX
// byte stays valid and stable until accepted; rsp_valid is a single-cycle pulse.
module spy_master
  import spy_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic        spy_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_byte,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic        busy,
  output spy_state_e  fsm_state
);

  spy_state_e  state, next_state;
  logic        write_q;
  logic [4:0]  addr_q;
  logic [15:0] wdata_q;
  logic        load_rsp;
  logic        rsp_err_d;
  logic [15:0] rsp_data_d;
  logic        rx_start;
  logic        rx_active;
  logic        byte_done;
  logic        tag_err;
  logic        timeout;
  logic [15:0] result;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_DONE);
  assign fsm_state = state;
  assign rx_active = (state == ST_RX_WAIT);
  assign rx_start  = (state == ST_TX_OP) && tx_ready && !write_q;

  always_ff @(posedge spy_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge spy_clk) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= 5'd0;
      wdata_q <= 16'h0000;
    end else if (cmd_valid && cmd_ready) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
    end
  end

  always_ff @(posedge spy_clk) begin
    if (reset) begin
      rsp_err  <= 1'b0;
      rsp_data <= 16'h0000;
    end else if (load_rsp) begin
      rsp_err  <= rsp_err_d;
      rsp_data <= rsp_data_d;
    end
  end

  always_comb begin
    next_state = state;
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    load_rsp   = 1'b0;
    rsp_err_d  = 1'b0;
    rsp_data_d = 16'h0000;
    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) next_state = cmd_write ? ST_TX_D3 : ST_TX_OP;
      end
      ST_TX_D3: begin
        tx_valid = 1'b1;
        tx_byte  = {SET_D3, wdata_q[15:12]};
        if (tx_ready) next_state = ST_TX_D2;
      end
      ST_TX_D2: begin
        tx_valid = 1'b1;
        tx_byte  = {SET_D2, wdata_q[11:8]};
        if (tx_ready) next_state = ST_TX_D1;
      end
      ST_TX_D1: begin
        tx_valid = 1'b1;
        tx_byte  = {SET_D1, wdata_q[7:4]};
        if (tx_ready) next_state = ST_TX_D0;
      end
      ST_TX_D0: begin
        tx_valid = 1'b1;
        tx_byte  = {SET_D0, wdata_q[3:0]};
        if (tx_ready) next_state = ST_TX_OP;
      end
      ST_TX_OP: begin
        tx_valid = 1'b1;
        tx_byte  = op_byte(write_q, addr_q);
        if (tx_ready) begin
          // A write is complete once its opcode leaves; reads await the reply.
          if (write_q) begin
            next_state = ST_DONE;
            load_rsp   = 1'b1;
          end else begin
            next_state = ST_RX_WAIT;
          end
        end
      end
      ST_RX_WAIT: begin
        if (byte_done) begin
          next_state = ST_DONE;
          load_rsp   = 1'b1;
          rsp_data_d = result;
        end else if (tag_err || timeout) begin
          next_state = ST_DONE;
          load_rsp   = 1'b1;
          rsp_err_d  = 1'b1;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  spy_rx_collect #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx_collect (
    .spy_clk  (spy_clk),
    .reset    (reset),
    .start    (rx_start),
    .active   (rx_active),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .byte_done(byte_done),
    .tag_err  (tag_err),
    .timeout  (timeout),
    .result   (result)
  );

endmodule

// File: tb/tb_spy_master.sv
// Self-checking bench for spy_master: directed protocol cases, then randomized
// commands checked against a cycle-level model of the byte protocol.
module tb_spy_master;
  import spy_pkg::*;

  localparam int TMO = 100;

  logic        spy_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        busy;
  spy_state_e  fsm_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] last_rsp_data;

  // Response scenario for the next read: bytes, idle cycles before each byte.
  logic [7:0]  rx_seq [4];
  int          rx_gap [4];
  // Model outputs: error flag, data, RX_WAIT-entry-to-rsp offset, byte slots.
  bit          m_err;
  logic [15:0] m_data;
  int          m_off;
  int          m_pos [4];

  spy_master #(.TIMEOUT_CYCLES(24'(TMO))) dut (
    .spy_clk  (spy_clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_byte  (tx_byte),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .busy     (busy),
    .fsm_state(fsm_state)
  );

  always #5 spy_clk = ~spy_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge spy_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reply model: a gap of TMO idle cycles ends the read with an error TMO
  // cycles after the gap began; a wrong tag ends it the cycle after that byte.
  function automatic void model_read();
    int t;
    t      = 0;
    m_err  = 1'b0;
    m_data = 16'h0000;
    m_off  = -1;
    for (int i = 0; i < 4; i++) begin
      m_pos[i] = t + rx_gap[i];
      if (m_off < 0) begin
        if (rx_gap[i] >= TMO) begin
          m_err  = 1'b1;
          m_data = 16'h0000;
          m_off  = t + TMO;
        end else if (int'(rx_seq[i][7:4]) != 3 + i) begin
          m_err  = 1'b1;
          m_data = 16'h0000;
          m_off  = m_pos[i] + 1;
        end else begin
          m_data = {m_data[11:0], rx_seq[i][3:0]};
        end
      end
      t = m_pos[i] + 1;
    end
    if (m_off < 0) m_off = t;
  endfunction

  task automatic do_cmd(input bit write, input logic [4:0] addr, input logic [15:0] wdata,
                        input bit rand_ready, input bit junk, input bit min_lat);
    logic [7:0] exp_q[$];
    int         cyc, rx_start, exp_rsp, rel;
    bit         seen, prev_tv, prev_rdy, rdy;
    logic [7:0] prev_byte, b;
    logic [15:0] exp_data;
    bit          exp_err;

    if (write) begin
      exp_q.push_back({4'h3, wdata[15:12]});
      exp_q.push_back({4'h4, wdata[11:8]});
      exp_q.push_back({4'h5, wdata[7:4]});
      exp_q.push_back({4'h6, wdata[3:0]});
      exp_data = 16'h0000;
      exp_err  = 1'b0;
    end else begin
      model_read();
      exp_data = m_data;
      exp_err  = m_err;
    end
    exp_q.push_back({2'b10, write, addr});

    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    check("rsp_data_hold", 32'(rsp_data), 32'(last_rsp_data));

    cmd_valid = 1'b1;
    cmd_write = write;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    tx_ready  = 1'b1;
    rx_valid  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
    rx_byte   = 8'($urandom);
    step();
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 5'($urandom);
    cmd_wdata = 16'($urandom);

    cyc      = 1;
    rx_start = -1;
    exp_rsp  = -1;
    seen     = 1'b0;
    prev_tv  = 1'b0;
    prev_rdy = 1'b1;
    prev_byte = 8'h00;
    while (!seen && cyc < 600) begin
      if (rsp_valid) begin
        seen = 1'b1;
        check("rsp_cycle", 32'(cyc), 32'(exp_rsp));
        if (min_lat) check("min_latency", 32'(cyc), 32'd6);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("ready_in_done", 32'(cmd_ready), 32'd0);
        check("tx_left", 32'(exp_q.size()), 32'd0);
        last_rsp_data = exp_data;
      end else begin
        if (prev_tv && !prev_rdy) check("tx_hold", 32'({tx_valid, tx_byte}), 32'({1'b1, prev_byte}));
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        tx_ready = rdy;
        if (tx_valid && rdy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL tx_extra: observed byte 0x%0h expected no byte", tx_byte);
          end else begin
            b = exp_q.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(b));
            if (exp_q.size() == 0) begin
              if (write) exp_rsp = cyc + 1;
              else begin
                rx_start = cyc + 1;
                exp_rsp  = rx_start + m_off;
              end
            end
          end
        end
        if (rx_start >= 0 && cyc >= rx_start) begin
          rel      = cyc - rx_start;
          rx_valid = 1'b0;
          rx_byte  = 8'($urandom);
          for (int i = 0; i < 4; i++) begin
            if (rel == m_pos[i]) begin
              rx_valid = 1'b1;
              rx_byte  = rx_seq[i];
            end
          end
        end else begin
          rx_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
          rx_byte  = 8'($urandom);
        end
        prev_tv   = tx_valid;
        prev_rdy  = rdy;
        prev_byte = tx_byte;
      end
      step();
      cyc++;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $error("FAIL rsp_missing: observed no rsp_valid expected one within 600 cycles");
    end
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
    check("ready_after", 32'(cmd_ready), 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic set_rx(input logic [31:0] bytes, input int g0, input int g1, input int g2, input int g3);
    rx_seq[0] = bytes[31:24];
    rx_seq[1] = bytes[23:16];
    rx_seq[2] = bytes[15:8];
    rx_seq[3] = bytes[7:0];
    rx_gap[0] = g0;
    rx_gap[1] = g1;
    rx_gap[2] = g2;
    rx_gap[3] = g3;
  endtask

  initial begin
    logic [31:0] rb;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 5'd0;
    cmd_wdata = 16'h0000;
    tx_ready  = 1'b1;
    rx_valid  = 1'b0;
    rx_byte   = 8'h00;
    last_rsp_data = 16'h0000;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Directed write and read with full-rate handshakes.
    do_cmd(1'b1, 5'h05, 16'h1234, 1'b0, 1'b0, 1'b1);
    set_rx(32'h3D4E5A6D, 0, 0, 0, 0);
    do_cmd(1'b0, 5'h13, 16'h0000, 1'b0, 1'b0, 1'b1);
    check("dead_value", 32'(rsp_data), 32'h0000DEAD);

    // Silent reply, then a bad tag with trailing bytes that must be ignored.
    set_rx(32'h3D4E5A6D, 200, 0, 0, 0);
    do_cmd(1'b0, 5'h02, 16'h0000, 1'b0, 1'b0, 1'b0);
    set_rx(32'h3D5A4E6D, 0, 0, 0, 0);
    do_cmd(1'b0, 5'h1F, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Idle gap one short of the limit is fine; exactly the limit times out.
    set_rx(32'h31425364, 99, 0, 99, 0);
    do_cmd(1'b0, 5'h07, 16'h0000, 1'b0, 1'b0, 1'b0);
    set_rx(32'h3A4B5C6D, 0, 100, 0, 0);
    do_cmd(1'b0, 5'h18, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Writes under a stalling transmitter with rx noise.
    for (int k = 0; k < 3; k++) do_cmd(1'b1, 5'($urandom), 16'($urandom), 1'b1, 1'b1, 1'b0);

    // Reset in RX_WAIT after two reply bytes.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 5'h0A;
    tx_ready  = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("rm_op_byte", 32'({tx_valid, tx_byte}), 32'h18A);
    step();
    rx_valid = 1'b1;
    rx_byte  = 8'h31;
    step();
    rx_byte  = 8'h42;
    step();
    rx_valid = 1'b0;
    check("rm_busy", 32'(busy), 32'd1);
    check("rm_no_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rm_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rm_idle", 32'(cmd_ready), 32'd1);
    check("rm_tx_valid", 32'(tx_valid), 32'd0);
    check("rm_busy_low", 32'(busy), 32'd0);
    last_rsp_data = 16'h0000;
    set_rx(32'h3C4A5F6E, 0, 1, 0, 2);
    do_cmd(1'b0, 5'h0A, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Randomized mix of commands, stalls, gaps and corrupted tags.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 4; i++) begin
        rb[31-8*i -: 8] = {4'(3 + i), 4'($urandom)};
        if ($urandom_range(0, 9) == 0) rb[31-8*i -: 4] = 4'($urandom);
      end
      set_rx(rb,
             ($urandom_range(0, 9) == 0) ? $urandom_range(95, 105) : $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      do_cmd(1'($urandom), 5'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
